// File: rtl/syn_fifo_ctrl.sv
// Single-clock FIFO controller with arbitrary depth, optional first-word-fall-through
// read timing, occupancy count, almost-full/empty thresholds, flush and sticky error flags.
module syn_fifo_ctrl #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 0,
    parameter int AFULL_TH   = DEPTH - 2,
    parameter int AEMPTY_TH  = 2,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  aempty,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_WIDTH = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_WIDTH-1:0]  wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0]  rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc_s;
    logic                  rd_acc_s;

    // Pointer increment with wrap at DEPTH-1, so index DEPTH never appears.
    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
        if (ptr == PTR_WIDTH'(DEPTH - 1)) begin
            return PTR_WIDTH'(0);
        end else begin
            return ptr + PTR_WIDTH'(1);
        end
    endfunction

    // Status flags as a function of an occupancy value: {full, empty, afull, aempty}.
    function automatic logic [3:0] flags_of(input logic [CNT_WIDTH-1:0] c);
        logic [3:0] f;
        f[3] = (c == CNT_WIDTH'(DEPTH));
        f[2] = (c == CNT_WIDTH'(0));
        f[1] = (c >= CNT_WIDTH'(AFULL_TH));
        f[0] = (c <= CNT_WIDTH'(AEMPTY_TH));
        return f;
    endfunction

    // Next-state computation for pointers, count, read port and sticky flags.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        rvalid_d    = rvalid_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_acc_s    = 1'b0;
        rd_acc_s    = 1'b0;

        if (flush) begin
            wptr_d      = PTR_WIDTH'(0);
            rptr_d      = PTR_WIDTH'(0);
            count_d     = CNT_WIDTH'(0);
            rvalid_d    = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            wr_acc_s    = w_en & ~full_q;
            rd_acc_s    = r_en & ~empty_q;
            overflow_d  = overflow_q | (w_en & full_q);
            underflow_d = underflow_q | (r_en & empty_q);

            if (wr_acc_s) begin
                wptr_d = next_ptr(wptr_q);
            end else begin
                wptr_d = wptr_q;
            end

            if (rd_acc_s) begin
                rptr_d = next_ptr(rptr_q);
            end else begin
                rptr_d = rptr_q;
            end

            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase

            if (FWFT != 0) begin
                // Present the head of the next state; forward wdata when the head slot is being written now.
                rvalid_d = (count_d != CNT_WIDTH'(0));
                if (count_d == CNT_WIDTH'(0)) begin
                    rdata_d = rdata_q;
                end else if (wr_acc_s && (wptr_q == rptr_d)) begin
                    rdata_d = wdata;
                end else begin
                    rdata_d = mem_q[rptr_d];
                end
            end else begin
                rvalid_d = rd_acc_s;
                if (rd_acc_s) begin
                    rdata_d = mem_q[rptr_q];
                end else begin
                    rdata_d = rdata_q;
                end
            end
        end

        {full_d, empty_d, afull_d, aempty_d} = flags_of(count_d);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= PTR_WIDTH'(0);
            rptr_q      <= PTR_WIDTH'(0);
            count_q     <= CNT_WIDTH'(0);
            rdata_q     <= DATA_WIDTH'(0);
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            {full_q, empty_q, afull_q, aempty_q} <= flags_of(CNT_WIDTH'(0));
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc_s) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign afull     = afull_q;
    assign aempty    = aempty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_syn_fifo_ctrl.sv
// Bench for syn_fifo_ctrl: three configurations share one stimulus bus and are checked
// against a queue-based reference model plus directed expectations.
module tb_syn_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, flush, w_en, r_en;
    logic [7:0] wdata;

    logic [7:0] a_rdata, b_rdata, c_rdata;
    logic       a_rvalid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
    logic       b_rvalid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
    logic       c_rvalid, c_full, c_empty, c_afull, c_aempty, c_ovf, c_unf;
    logic [2:0] a_count, c_count;
    logic [4:0] b_count;

    int errors = 0;
    int checks = 0;

    // A: DEPTH=5 standard read
    syn_fifo_ctrl #(.DEPTH(5), .DATA_WIDTH(8), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(1)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .wdata(wdata), .r_en(r_en),
        .rdata(a_rdata), .rvalid(a_rvalid), .full(a_full), .empty(a_empty), .afull(a_afull),
        .aempty(a_aempty), .count(a_count), .overflow(a_ovf), .underflow(a_unf));
    // B: DEPTH=16 fall-through
    syn_fifo_ctrl #(.DEPTH(16), .DATA_WIDTH(8), .FWFT(1), .AFULL_TH(14), .AEMPTY_TH(2)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .wdata(wdata), .r_en(r_en),
        .rdata(b_rdata), .rvalid(b_rvalid), .full(b_full), .empty(b_empty), .afull(b_afull),
        .aempty(b_aempty), .count(b_count), .overflow(b_ovf), .underflow(b_unf));
    // C: DEPTH=4 standard read
    syn_fifo_ctrl #(.DEPTH(4), .DATA_WIDTH(8), .FWFT(0), .AFULL_TH(2), .AEMPTY_TH(1)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .wdata(wdata), .r_en(r_en),
        .rdata(c_rdata), .rvalid(c_rvalid), .full(c_full), .empty(c_empty), .afull(c_afull),
        .aempty(c_aempty), .count(c_count), .overflow(c_ovf), .underflow(c_unf));

    logic [19:0] obs [3];
    assign obs[0] = {a_rdata, a_rvalid, a_full, a_empty, a_afull, a_aempty, 2'b00, a_count, a_ovf, a_unf};
    assign obs[1] = {b_rdata, b_rvalid, b_full, b_empty, b_afull, b_aempty, b_count, b_ovf, b_unf};
    assign obs[2] = {c_rdata, c_rvalid, c_full, c_empty, c_afull, c_aempty, 2'b00, c_count, c_ovf, c_unf};

    // Reference model: a queue of stored words per configuration
    logic [7:0] mq [3][$];
    logic [7:0] m_rd [3];
    logic       m_rv [3];
    logic       m_ov [3];
    logic       m_un [3];

    function automatic int dep(int i);
        case (i) 0: return 5; 1: return 16; default: return 4; endcase
    endfunction
    function automatic int fw(int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int af(int i);
        case (i) 0: return 3; 1: return 14; default: return 2; endcase
    endfunction
    function automatic int ae(int i);
        case (i) 0: return 1; 1: return 2; default: return 1; endcase
    endfunction

    function automatic logic [19:0] exp_vec(int i);
        int n;
        n = mq[i].size();
        return {m_rd[i], m_rv[i], (n == dep(i)), (n == 0), (n >= af(i)), (n <= ae(i)),
                5'(n), m_ov[i], m_un[i]};
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit wa, ra;
            if (!rst_n) begin
                mq[i].delete();
                m_rd[i] = 8'h00; m_rv[i] = 1'b0; m_ov[i] = 1'b0; m_un[i] = 1'b0;
            end else if (flush) begin
                mq[i].delete();
                m_rv[i] = 1'b0; m_ov[i] = 1'b0; m_un[i] = 1'b0;
            end else begin
                wa = w_en && (mq[i].size() < dep(i));
                ra = r_en && (mq[i].size() > 0);
                if (w_en && !wa) m_ov[i] = 1'b1;
                if (r_en && !ra) m_un[i] = 1'b1;
                if (fw(i) == 0) begin
                    m_rv[i] = ra;
                    if (ra) m_rd[i] = mq[i][0];
                end
                if (ra) void'(mq[i].pop_front());
                if (wa) mq[i].push_back(wdata);
                if (fw(i) != 0) begin
                    m_rv[i] = (mq[i].size() > 0);
                    if (mq[i].size() > 0) m_rd[i] = mq[i][0];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; w_en = 1'b0; r_en = 1'b0;
    endtask

    task automatic do_reset();
        idle(); rst_n = 1'b0; tick(); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle(); rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        checks++; if (a_count !== 3'd0 || a_empty !== 1'b1 || a_full !== 1'b0) begin errors++;
            $display("FAIL reset_a: count=%0d empty=%b full=%b required 0 1 0", a_count, a_empty, a_full); end
        checks++; if (a_afull !== 1'b0 || a_aempty !== 1'b1 || a_rvalid !== 1'b0 || a_rdata !== 8'h00) begin errors++;
            $display("FAIL reset_a_flags: afull=%b aempty=%b rvalid=%b rdata=%h required 0 1 0 00", a_afull, a_aempty, a_rvalid, a_rdata); end
        checks++; if (b_rdata !== 8'h00 || b_rvalid !== 1'b0 || b_ovf !== 1'b0 || b_unf !== 1'b0) begin errors++;
            $display("FAIL reset_b: rdata=%h rvalid=%b ovf=%b unf=%b required 00 0 0 0", b_rdata, b_rvalid, b_ovf, b_unf); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs[i] !== exp_vec(i)) begin errors++;
                $display("FAIL reset_model[%0d]: got %h required %h", i, obs[i], exp_vec(i)); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int rnd = 0; rnd < 3; rnd++) begin
            idle();
            for (int k = 0; k < 5; k++) begin w_en = 1'b1; wdata = 8'(8'h11 + k); tick(); end
            checks++; if (a_full !== 1'b1 || a_count !== 3'd5) begin errors++;
                $display("FAIL wrap_full: full=%b count=%0d required 1 5", a_full, a_count); end
            wdata = 8'h16; tick(); w_en = 1'b0;
            checks++; if (a_ovf !== 1'b1 || a_count !== 3'd5) begin errors++;
                $display("FAIL wrap_overflow: ovf=%b count=%0d required 1 5", a_ovf, a_count); end
            for (int k = 0; k < 5; k++) begin
                r_en = 1'b1; tick();
                checks++; if (a_rdata !== 8'(8'h11 + k) || a_rvalid !== 1'b1) begin errors++;
                    $display("FAIL wrap_read: rdata=%h rvalid=%b required %h 1", a_rdata, a_rvalid, 8'(8'h11 + k)); end
                r_en = 1'b0; tick();
                checks++; if (a_rvalid !== 1'b0 || a_rdata !== 8'(8'h11 + k)) begin errors++;
                    $display("FAIL wrap_rvalid_drop: rvalid=%b rdata=%h required 0 %h", a_rvalid, a_rdata, 8'(8'h11 + k)); end
            end
            checks++; if (a_empty !== 1'b1) begin errors++;
                $display("FAIL wrap_empty: empty=%b required 1", a_empty); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs[i] !== exp_vec(i)) begin errors++;
                $display("FAIL wrap_model[%0d]: got %h required %h", i, obs[i], exp_vec(i)); end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int k = 0; k < 4; k++) begin w_en = 1'b1; wdata = 8'(8'h40 + k); tick(); end
        checks++; if (c_full !== 1'b1) begin errors++; $display("FAIL simul_fill: full=%b required 1", c_full); end
        w_en = 1'b1; r_en = 1'b1; wdata = 8'hEE; tick(); idle();
        checks++; if (c_count !== 3'd3 || c_ovf !== 1'b1 || c_rvalid !== 1'b1 || c_rdata !== 8'h40) begin errors++;
            $display("FAIL simul_full: count=%0d ovf=%b rvalid=%b rdata=%h required 3 1 1 40", c_count, c_ovf, c_rvalid, c_rdata); end
        do_reset();
        w_en = 1'b1; r_en = 1'b1; wdata = 8'h5A; tick(); idle();
        checks++; if (c_count !== 3'd1 || c_unf !== 1'b1 || c_rvalid !== 1'b0 || c_ovf !== 1'b0) begin errors++;
            $display("FAIL simul_empty: count=%0d unf=%b rvalid=%b ovf=%b required 1 1 0 0", c_count, c_unf, c_rvalid, c_ovf); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs[i] !== exp_vec(i)) begin errors++;
                $display("FAIL simul_model[%0d]: got %h required %h", i, obs[i], exp_vec(i)); end
        end
    endtask

    task automatic test_fwft();
        do_reset();
        w_en = 1'b1; wdata = 8'hA5; tick(); idle();
        checks++; if (b_rdata !== 8'hA5 || b_rvalid !== 1'b1) begin errors++;
            $display("FAIL fwft_show: rdata=%h rvalid=%b required a5 1", b_rdata, b_rvalid); end
        r_en = 1'b1; tick(); idle();
        checks++; if (b_empty !== 1'b1 || b_rvalid !== 1'b0 || b_rdata !== 8'hA5) begin errors++;
            $display("FAIL fwft_pop: empty=%b rvalid=%b rdata=%h required 1 0 a5", b_empty, b_rvalid, b_rdata); end
    endtask

    task automatic test_thresholds();
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            w_en = 1'b1; wdata = 8'($urandom); tick();
            checks++; if (b_count !== 5'(k) || b_aempty !== (k <= 2) || b_afull !== (k >= 14)) begin errors++;
                $display("FAIL thresh_fill: count=%0d aempty=%b afull=%b required %0d %b %b", b_count, b_aempty, b_afull, k, (k <= 2), (k >= 14)); end
        end
        idle();
        for (int k = 15; k >= 0; k--) begin
            r_en = 1'b1; tick();
            checks++; if (b_count !== 5'(k) || b_aempty !== (k <= 2) || b_afull !== (k >= 14)) begin errors++;
                $display("FAIL thresh_drain: count=%0d aempty=%b afull=%b required %0d %b %b", b_count, b_aempty, b_afull, k, (k <= 2), (k >= 14)); end
        end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 17; k++) begin w_en = 1'b1; wdata = 8'(k); tick(); end
        w_en = 1'b0;
        for (int k = 0; k < 9; k++) begin r_en = 1'b1; tick(); end
        r_en = 1'b0;
        checks++; if (b_count !== 5'd7 || b_ovf !== 1'b1) begin errors++;
            $display("FAIL flush_setup: count=%0d ovf=%b required 7 1", b_count, b_ovf); end
        flush = 1'b1; w_en = 1'b1; r_en = 1'b1; wdata = 8'hC3; tick(); idle();
        checks++; if (b_count !== 5'd0 || b_empty !== 1'b1 || b_ovf !== 1'b0 || b_unf !== 1'b0 || b_rvalid !== 1'b0) begin errors++;
            $display("FAIL flush_clear: count=%0d empty=%b ovf=%b unf=%b rvalid=%b required 0 1 0 0 0", b_count, b_empty, b_ovf, b_unf, b_rvalid); end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs[i] !== exp_vec(i)) begin errors++;
                $display("FAIL flush_model[%0d]: got %h required %h", i, obs[i], exp_vec(i)); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 9; k++) begin w_en = 1'b1; wdata = 8'(8'h80 + k); tick(); end
        idle(); rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++; if (b_count !== 5'd0 || b_rdata !== 8'h00 || b_empty !== 1'b1 || b_aempty !== 1'b1 || b_afull !== 1'b0 || b_rvalid !== 1'b0) begin errors++;
            $display("FAIL reset_mid: count=%0d rdata=%h empty=%b aempty=%b afull=%b rvalid=%b required 0 00 1 1 0 0", b_count, b_rdata, b_empty, b_aempty, b_afull, b_rvalid); end
        w_en = 1'b1; wdata = 8'h77; tick(); idle();
        checks++; if (b_rdata !== 8'h77 || b_count !== 5'd1) begin errors++;
            $display("FAIL reset_mid_new: rdata=%h count=%0d required 77 1", b_rdata, b_count); end
        r_en = 1'b1; tick(); idle();
        checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL reset_mid_pop: empty=%b required 1", b_empty); end
    endtask

    task automatic test_random();
        int wp;
        do_reset();
        wp = 50;
        for (int n = 0; n < 3000; n++) begin
            if ((n % 100) == 0) wp = $urandom_range(15, 85);
            rst_n = ($urandom_range(0, 299) != 0);
            flush = ($urandom_range(0, 79) == 0);
            w_en  = ($urandom_range(0, 99) < wp);
            r_en  = ($urandom_range(0, 99) < (100 - wp));
            wdata = 8'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++; if (obs[i] !== exp_vec(i)) begin errors++;
                    $display("FAIL random_model[%0d] cycle %0d: got %h required %h", i, n, obs[i], exp_vec(i)); end
            end
        end
        rst_n = 1'b1; idle();
    endtask

    initial begin
        rst_n = 1'b0; wdata = 8'h00;
        idle();
        test_reset();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_thresholds();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
